// File: rtl/cacheline_burst_adaptor.sv
// Bridges single-request 256-bit L2 line reads/writes onto a 64-bit, 4-beat burst memory port.
// Reads gather beats into a line buffer; writes stream the latched line out one beat at a time.
module cacheline_burst_adaptor #(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_offset = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [s_line-1:0]  pmem_wdata,
    output logic [s_line-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [s_burst-1:0] burst_wdata,
    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int BEATS = s_line / s_burst;
    localparam int W_CNT = $clog2(BEATS);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
    localparam logic [W_CNT-1:0] LAST_BEAT = W_CNT'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_reg;
    logic [W_CNT-1:0]    cnt_reg;
    logic [s_line-1:0]   line_buf_reg;
    logic [s_line-1:0]   rdata_reg;
    logic [31:0]         addr_reg;
    logic                resp_reg;
    logic                read_reg;
    logic                write_reg;
    logic [s_line-1:0]   line_next;
    logic [s_burst-1:0]  beat_arr [BEATS];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_arr[gi] = line_buf_reg[gi*s_burst +: s_burst];
        end
    endgenerate

    // Line buffer with the current read beat merged in; also the final line on the last beat.
    always_comb begin
        line_next = line_buf_reg;
        line_next[cnt_reg*s_burst +: s_burst] = burst_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            line_buf_reg <= '0;
            rdata_reg    <= '0;
            addr_reg     <= '0;
            resp_reg     <= 1'b0;
            read_reg     <= 1'b0;
            write_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (pmem_write) begin
                        addr_reg     <= pmem_address;
                        line_buf_reg <= pmem_wdata;
                        write_reg    <= 1'b1;
                        state_reg    <= WRITE;
                    end else if (pmem_read) begin
                        addr_reg  <= pmem_address;
                        read_reg  <= 1'b1;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        line_buf_reg <= line_next;
                        cnt_reg      <= cnt_reg + W_CNT'(1);
                        if (cnt_reg == LAST_BEAT) begin
                            rdata_reg <= line_next;
                            read_reg  <= 1'b0;
                            resp_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        cnt_reg <= cnt_reg + W_CNT'(1);
                        if (cnt_reg == LAST_BEAT) begin
                            write_reg <= 1'b0;
                            resp_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pmem_resp     = resp_reg;
    assign pmem_rdata    = rdata_reg;
    assign burst_read    = read_reg;
    assign burst_write   = write_reg;
    assign burst_address = (state_reg == IDLE) ? '0 : (addr_reg & LINE_MASK);
    assign burst_wdata   = write_reg ? beat_arr[cnt_reg] : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: reads, writes, wait states, priority,
// back-to-back transactions and a mid-burst asynchronous reset.
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst_n;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int checks = 0;
    int fails  = 0;

    cacheline_burst_adaptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_address(burst_address),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;

    initial begin
        logic [63:0] rd_beats [4];
        logic [63:0] wr_beats [4];
        int          pat [7];
        int          k;
        int          read_cycles;

        rst_n = 1'b0; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
        tick(); tick();
        check("rst_resp", 256'(pmem_resp), 256'd0);
        check("rst_bread", 256'(burst_read), 256'd0);
        check("rst_bwrite", 256'(burst_write), 256'd0);
        check("rst_addr", 256'(burst_address), 256'd0);
        check("rst_wdata", 256'(burst_wdata), 256'd0);
        check("rst_rdata", pmem_rdata, 256'd0);
        rst_n = 1'b1;
        tick();

        // Zero-wait read
        rd_beats[0] = B1; rd_beats[1] = B2; rd_beats[2] = B3; rd_beats[3] = B4;
        pmem_read = 1'b1; pmem_address = 32'h0000_1234;
        tick();
        check("rd_bread", 256'(burst_read), 256'd1);
        check("rd_addr", 256'(burst_address), 256'h0000_1220);
        burst_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            burst_rdata = rd_beats[i];
            check("rd_resp_low", 256'(pmem_resp), 256'd0);
            tick();
        end
        check("rd_resp", 256'(pmem_resp), 256'd1);
        check("rd_bread_done", 256'(burst_read), 256'd0);
        check("rd_rdata", pmem_rdata, {B4, B3, B2, B1});
        pmem_read = 1'b0;
        tick();
        burst_resp = 1'b0;
        check("rd_resp_pulse", 256'(pmem_resp), 256'd0);
        check("rd_addr_idle", 256'(burst_address), 256'd0);
        check("rd_rdata_hold", pmem_rdata, {B4, B3, B2, B1});

        // Zero-wait write, request fields changed mid-transaction
        wr_beats[0] = WA; wr_beats[1] = WB; wr_beats[2] = WC; wr_beats[3] = WD;
        pmem_write = 1'b1; pmem_address = 32'h8000_00FF; pmem_wdata = {WD, WC, WB, WA};
        tick();
        pmem_address = 32'h1234_5678; pmem_wdata = '1;
        check("wr_bwrite", 256'(burst_write), 256'd1);
        check("wr_bread", 256'(burst_read), 256'd0);
        burst_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wr_addr", 256'(burst_address), 256'h8000_00E0);
            check("wr_wdata", 256'(burst_wdata), 256'(wr_beats[i]));
            tick();
        end
        check("wr_resp", 256'(pmem_resp), 256'd1);
        check("wr_bwrite_done", 256'(burst_write), 256'd0);
        check("wr_rdata_kept", pmem_rdata, {B4, B3, B2, B1});
        pmem_write = 1'b0;
        tick();
        burst_resp = 1'b0;
        check("wr_resp_pulse", 256'(pmem_resp), 256'd0);
        check("wr_bwrite_idle", 256'(burst_write), 256'd0);

        // Read with wait states: burst_resp pattern 1,0,0,1,1,0,1
        pat = '{1, 0, 0, 1, 1, 0, 1};
        rd_beats[0] = 64'h0101_0101_0101_0101; rd_beats[1] = 64'h0202_0202_0202_0202;
        rd_beats[2] = 64'h0303_0303_0303_0303; rd_beats[3] = 64'h0404_0404_0404_0404;
        pmem_read = 1'b1; pmem_address = 32'h0000_0040;
        tick();
        k = 0; read_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            if (burst_read) read_cycles++;
            check("ws_resp_low", 256'(pmem_resp), 256'd0);
            burst_resp  = (pat[i] != 0);
            burst_rdata = (pat[i] != 0) ? rd_beats[k] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[i] != 0) k++;
            tick();
        end
        check("ws_read_cycles", 256'(read_cycles), 256'd7);
        check("ws_resp", 256'(pmem_resp), 256'd1);
        check("ws_rdata", pmem_rdata, {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        pmem_read = 1'b0; burst_resp = 1'b0;
        tick();

        // Simultaneous read and write: write wins
        pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0100;
        pmem_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
        tick();
        check("pri_bwrite", 256'(burst_write), 256'd1);
        check("pri_bread", 256'(burst_read), 256'd0);
        burst_resp = 1'b1;
        tick(); tick(); tick(); tick();
        check("pri_resp", 256'(pmem_resp), 256'd1);
        pmem_read = 1'b0; pmem_write = 1'b0; burst_resp = 1'b0;
        tick();

        // Back-to-back: write, then read requested while write completes
        pmem_write = 1'b1; pmem_address = 32'h0000_0200; pmem_wdata = {WA, WB, WC, WD};
        tick();
        burst_resp = 1'b1;
        tick(); tick(); tick(); tick();
        check("b2b_wr_resp", 256'(pmem_resp), 256'd1);
        pmem_write = 1'b0; pmem_read = 1'b1; pmem_address = 32'h0000_0300;
        burst_resp = 1'b0;
        tick();
        check("b2b_idle_resp", 256'(pmem_resp), 256'd0);
        check("b2b_idle_bread", 256'(burst_read), 256'd0);
        check("b2b_idle_bwrite", 256'(burst_write), 256'd0);
        tick();
        check("b2b_rd_bread", 256'(burst_read), 256'd1);
        check("b2b_rd_addr", 256'(burst_address), 256'h0000_0300);
        burst_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            burst_rdata = 64'(i + 5);
            tick();
        end
        check("b2b_rd_resp", 256'(pmem_resp), 256'd1);
        check("b2b_rd_rdata", pmem_rdata, {64'd8, 64'd7, 64'd6, 64'd5});
        pmem_read = 1'b0; burst_resp = 1'b0;
        tick();

        // Asynchronous reset after the second read beat
        pmem_read = 1'b1; pmem_address = 32'h0000_0400;
        tick();
        burst_resp = 1'b1;
        burst_rdata = B1; tick();
        burst_rdata = B2; tick();
        check("ar_bread_before", 256'(burst_read), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_bread", 256'(burst_read), 256'd0);
        check("ar_addr", 256'(burst_address), 256'd0);
        check("ar_resp", 256'(pmem_resp), 256'd0);
        check("ar_rdata", pmem_rdata, 256'd0);
        pmem_read = 1'b0; burst_resp = 1'b0;
        tick();
        check("ar_resp_held", 256'(pmem_resp), 256'd0);
        rst_n = 1'b1;
        tick();
        check("ar_idle_resp", 256'(pmem_resp), 256'd0);

        // Read after reset completes normally
        pmem_read = 1'b1; pmem_address = 32'h0000_05FF;
        tick();
        check("pr_addr", 256'(burst_address), 256'h0000_05E0);
        burst_resp = 1'b1;
        burst_rdata = B4; tick();
        burst_rdata = B3; tick();
        burst_rdata = B2; tick();
        burst_rdata = B1; tick();
        check("pr_resp", 256'(pmem_resp), 256'd1);
        check("pr_rdata", pmem_rdata, {B1, B2, B3, B4});
        pmem_read = 1'b0; burst_resp = 1'b0;
        tick();
        check("pr_resp_pulse", 256'(pmem_resp), 256'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the L2 cache's physical-memory port. It accepts single-cycle-issued 256-bit line read/write requests and serves them over a 64-bit, 4-beat burst memory interface.
- Read path: collects four beats into a line.
- Write path: splits the line into four beats.
- It sits between the L2 cache and the DRAM/physical memory model.

Parameters:
- s_line, 256, line width in bits (matches L2 s_line).
- s_burst, 64, burst beat width in bits.
- s_offset, 5, line offset bits; the burst address is line-aligned.
- (derived) BEATS = s_line/s_burst = 4; W_CNT = $clog2(BEATS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pmem_address  in  32  line request address from L2.
- pmem_read  in  1  line read request; held by L2 until pmem_resp.
- pmem_write  in  1  line write request; held by L2 until pmem_resp.
- pmem_wdata  in  s_line  write line from L2.
- pmem_rdata  out  s_line  assembled read line.
- pmem_resp  out  1  one-cycle completion pulse to L2.
- burst_address  out  32  line-aligned burst address.
- burst_read  out  1  burst read request.
- burst_write  out  1  burst write request.
- burst_wdata  out  s_burst  current write beat.
- burst_rdata  in  s_burst  incoming read beat.
- burst_resp  in  1  beat handshake; one beat is transferred per cycle in which it is high.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, beat counter=0, line buffer=0, address register=0.
  - All outputs are 0: pmem_resp, burst_read, burst_write, burst_address, burst_wdata, pmem_rdata.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If pmem_write=1: latch pmem_address and pmem_wdata, go to WRITE. Write has priority if both requests are high.
  - Else if pmem_read=1: latch address, go to READ.
  - Counter cleared.
- Address: burst_address = {addr_reg[31:s_offset], s_offset'b0}. It is driven from the register, is stable for the whole transaction, and is 0 in IDLE.
- READ:
  - burst_read=1.
  - Each cycle with burst_resp=1: line_buf[cnt*s_burst +: s_burst] <= burst_rdata, cnt++.
  - The beat with cnt==BEATS-1 and burst_resp=1 transitions to DONE; burst_read drops in DONE.
  - Cycles with burst_resp=0 stall; the counter holds.
- WRITE:
  - burst_write=1, burst_wdata = line_buf[cnt*s_burst +: s_burst] (combinational from the counter).
  - Each burst_resp=1 advances cnt. The 4th accepted beat transitions to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata = line_buf (valid for reads).
  - Next state is IDLE unconditionally. A request still asserted on the IDLE cycle is treated as a new transaction, because L2 drops its request after sampling pmem_resp.
- pmem_rdata holds the last assembled line until the next read's DONE; it is not cleared in IDLE.
- Latency with zero-wait memory:
  - Request seen in IDLE (cycle 0).
  - Beats accepted on cycles 1–4.
  - pmem_resp on cycle 5.
  - Total is 6 cycles from request to next IDLE.
- Boundary rules:
  - Counter wraps 3→0 only on the final beat.
  - burst_resp in IDLE or DONE is ignored.
  - Request changes mid-transaction are ignored: address and data are latched.
  - Asserting rst_n low mid-burst aborts immediately. Outputs go to 0 and no pmem_resp is produced.
  - Exactly one of burst_read/burst_write is ever high.

Test Plan:
- Read, zero-wait: pmem_read=1, addr=0x0000_1234; burst_rdata beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - burst_address=0x0000_1220.
  - pmem_resp pulses one cycle at cycle 5.
  - pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, zero-wait: pmem_write=1, addr=0x8000_00FF, pmem_wdata = 256'h{D,C,B,A}×64-bit words.
  - burst_address=0x8000_00E0.
  - burst_wdata = A, B, C, D over 4 accepted beats.
  - pmem_resp is a single pulse and burst_write is 0 afterwards.
- Wait states: read with burst_resp pattern 1,0,0,1,1,0,1.
  - Beat order is preserved.
  - burst_read is held for 7 cycles.
  - pmem_resp occurs on the cycle after the 4th accepted beat.
- Simultaneous pmem_read=1 and pmem_write=1 in IDLE: WRITE is taken (burst_write=1, burst_read=0).
- Back-to-back: write then read with requests held through the IDLE cycle.
  - Two distinct transactions with two pmem_resp pulses.
  - The transactions are separated by exactly one IDLE cycle.
- Async reset after the 2nd read beat: all outputs drop to 0 without waiting for a clock edge, and there is no pmem_resp. A subsequent read completes normally.
